bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have one parameter: BIN_W, default 8, binary operand width; only 8 is supported, and the three BCD digit outputs are sized for a maximum value of 255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  conversion request; sampled on a rising clk edge.
REQ-005 bin_in  input  8  unsigned binary operand; sampled only on the edge that accepts start.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse: bcd_* outputs have just been updated.
REQ-008 bcd_100  output  4  hundreds digit, range 0..2.
REQ-009 bcd_10  output  4  tens digit, range 0..9.
REQ-010 bcd_1  output  4  units digit, range 0..9.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 IDLE with start=1 at edge E: the block SHALL capture bin_in into the shift register, clear the 12-bit digit scratch, clear the step counter, enter SHIFT and set busy=1.
REQ-013 IDLE with start=0: the block SHALL hold all state and outputs.
REQ-014 SHIFT, each edge: the block SHALL add 3 to each scratch digit that is >=5, then shift {scratch, binary} left by one bit and increment the step counter (3-bit, 0..7).
REQ-015 The 8th shift SHALL occur at edge E+8; on that edge the block SHALL load the corrected and shifted scratch into bcd_100/bcd_10/bcd_1, set done=1, set busy=0 and return to IDLE.
REQ-016 done SHALL be high for exactly the one cycle following E+8 and then return low.
REQ-017 Latency SHALL be fixed at 8 cycles from the accepting edge to visible results, independent of the operand value.
REQ-018 start while busy=1 SHALL be ignored and SHALL NOT be queued; bin_in changes during SHIFT SHALL have no effect.
REQ-019 start=1 in the cycle where done=1 SHALL be accepted, because the FSM is already in IDLE; this allows back-to-back conversions with a 9-cycle period.
REQ-020 The bcd_* outputs SHALL hold their last result until the next completion; they SHALL NOT show intermediate scratch values.
REQ-021 No digit SHALL ever exceed 9, and bcd_100 SHALL never exceed 2.

Reset
REQ-022 When rst_n=0 the block SHALL immediately force state=IDLE, busy=0, done=0, bcd_100=bcd_10=bcd_1=0, and clear the step counter, scratch and shift register.
REQ-023 Reset asserted during SHIFT SHALL abort the conversion: no done pulse and no output update.
REQ-024 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-025 A shared package bcd_pkg SHALL hold the FSM state enum, a 4-bit BCD digit typedef, and the constant ADD3_THRESHOLD=5.
REQ-026 The per-digit correction SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out, adds 3 when input >=5), instantiated three times.
REQ-027 All registers SHALL live in bin_to_bcd_seq; there SHALL be no latches.

Verification
REQ-028 Reset, then bin_in=0 and start at E -> done at E+8; bcd = 0,0,0.
REQ-029 bin_in=255 -> 2,5,5; bin_in=99 -> 0,9,9; bin_in=128 -> 1,2,8; each with busy high for exactly 8 cycles.
REQ-030 bin_in=37 with start at E, then start held high with bin_in=200 during E+1..E+7 -> single done at E+8 with 0,3,7.
REQ-031 Convert 57, then assert start with bin_in=146 in the done cycle -> second done 9 cycles after the first; outputs 1,4,6; 0,5,7 held until then.
REQ-032 Convert 42, then start 250 and pulse rst_n low at E+4 -> outputs 0,0,0 immediately, no done; a new start with 250 -> 2,5,0.
REQ-033 Exhaustive sweep of bin_in 0..255 against a reference model -> all digits match, all digits <=9, and done count equals 256.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter control states: waiting for a request, or shifting bits in.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // A digit at or above this value would overflow past 9 on the next shift,
  // so it gets 3 added first (double-dabble correction).
  localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;

  // Three digits cover an 8-bit operand (0..255).
  localparam int NUM_DIGITS = 3;
  localparam int SCRATCH_W  = 4 * NUM_DIGITS;

  // Width of the shift-step counter.
  localparam int STEP_W = 3;

  // True when a digit is a legal decimal value.
  function automatic logic digit_is_valid(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: adds 3 to a digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Pass the digit through unless it needs the pre-shift correction.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESHOLD) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// A request is accepted in IDLE; eight shift steps later the result is
// loaded into the output digits together with a one-cycle done pulse.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_100,
  output logic [3:0]       bcd_10,
  output logic [3:0]       bcd_1
);

  // Step index of the final shift; the conversion finishes on that edge.
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);
  localparam int WORD_W = SCRATCH_W + BIN_W;

  state_t                 state_reg, state_next;
  logic [STEP_W-1:0]      step_reg, step_next;
  logic [SCRATCH_W-1:0]   scratch_reg, scratch_next;
  logic [BIN_W-1:0]       bin_reg, bin_next;
  logic [SCRATCH_W-1:0]   bcd_reg, bcd_next;
  logic                   done_reg, done_next;

  // Corrected scratch digits and the combined word after one left shift.
  logic [SCRATCH_W-1:0]   scratch_corr;
  logic [WORD_W-1:0]      shift_word;
  logic [SCRATCH_W-1:0]   scratch_shifted;
  logic [BIN_W-1:0]       bin_shifted;

  // One correction cell per scratch digit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (scratch_reg[gi*4 +: 4]),
      .digit_out (scratch_corr[gi*4 +: 4])
    );
  end

  assign shift_word      = {scratch_corr, bin_reg} << 1;
  assign scratch_shifted = shift_word[WORD_W-1 -: SCRATCH_W];
  assign bin_shifted     = shift_word[BIN_W-1:0];

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    state_next   = state_reg;
    step_next    = step_reg;
    scratch_next = scratch_reg;
    bin_next     = bin_reg;
    bcd_next     = bcd_reg;
    done_next    = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          bin_next     = bin_in;
          scratch_next = '0;
          step_next    = '0;
          state_next   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // start and bin_in are deliberately ignored here: no queuing.
        scratch_next = scratch_shifted;
        bin_next     = bin_shifted;
        step_next    = step_reg + 1'b1;
        if (step_reg == LAST_STEP) begin
          bcd_next   = scratch_shifted;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: step counter, scratch, operand, results, done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg    <= '0;
      scratch_reg <= '0;
      bin_reg     <= '0;
      bcd_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      step_reg    <= step_next;
      scratch_reg <= scratch_next;
      bin_reg     <= bin_next;
      bcd_reg     <= bcd_next;
      done_reg    <= done_next;
    end
  end

  assign busy    = (state_reg == ST_SHIFT);
  assign done    = done_reg;
  assign bcd_100 = bcd_reg[11:8];
  assign bcd_10  = bcd_reg[7:4];
  assign bcd_1   = bcd_reg[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: the driver pushes decimal digits
// computed with plain arithmetic; a monitor pops them on every done pulse.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       busy, done;
  logic [3:0] bcd_100, bcd_10, bcd_1;

  bin_to_bcd_seq #(.BIN_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_100 (bcd_100),
    .bcd_10  (bcd_10),
    .bcd_1   (bcd_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int h;
    int t;
    int o;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int done_count = 0;
  int cycle = 0;
  int last_done_cycle = -1;
  int prev_done_cycle = -1;
  int last_h = 0, last_t = 0, last_o = 0;
  logic done_seen_prev = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    e.bin = v;
    e.h   = v / 100;
    e.t   = (v / 10) % 10;
    e.o   = v % 10;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_count++;
      prev_done_cycle = last_done_cycle;
      last_done_cycle = cycle;
      if (done_seen_prev) check("done_width", 2, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("bcd_100", int'(bcd_100), e.h);
        check("bcd_10", int'(bcd_10), e.t);
        check("bcd_1", int'(bcd_1), e.o);
        check("digit_range", int'(bcd_100 <= 4'd2 && bcd_10 <= 4'd9 && bcd_1 <= 4'd9), 1);
        last_h = e.h;
        last_t = e.t;
        last_o = e.o;
        $display("conv bin=%0d -> %0d %0d %0d (expected %0d %0d %0d)",
                 e.bin, bcd_100, bcd_10, bcd_1, e.h, e.t, e.o);
      end
    end
    done_seen_prev = done;
  end

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issue a request at the current negedge (DUT known idle) and follow it
  // through the eight busy cycles to the done cycle, where it returns.
  task automatic convert(input int v, input bit hold_start);
    exp_q.push_back(model(v));
    start  = 1'b1;
    bin_in = 8'(v);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("busy", int'(busy), 1);
      check("done_early", int'(done), 0);
      check("hold_outputs", int'({bcd_100, bcd_10, bcd_1}), last_h * 256 + last_t * 16 + last_o);
      if (k < 7) begin
        start  = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
        bin_in = hold_start ? 8'd200 : 8'($urandom);
      end else begin
        start  = 1'b0;
        bin_in = 8'($urandom);
      end
      @(negedge clk);
    end
    check("busy_end", int'(busy), 0);
    check("done_pulse", int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd", int'({bcd_100, bcd_10, bcd_1}), 0);
    rst_n = 1'b1;
    idle(2);

    // Directed values including both ends of the range.
    convert(0, 1'b0);   idle(1);
    convert(255, 1'b0); idle(1);
    convert(99, 1'b0);  idle(1);
    convert(128, 1'b0); idle(2);

    // start held during the conversion with a different operand.
    saved = done_count;
    convert(37, 1'b1);
    idle(3);
    check("held_start_single_done", done_count - saved, 1);

    // Back-to-back: second request issued in the done cycle.
    convert(57, 1'b0);
    convert(146, 1'b0);
    idle(2);
    check("b2b_period", last_done_cycle - prev_done_cycle, 9);

    // Reset in the middle of a conversion.
    convert(42, 1'b0);
    idle(1);
    saved = done_count;
    exp_q.push_back(model(250));
    start  = 1'b1;
    bin_in = 8'd250;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bcd", int'({bcd_100, bcd_10, bcd_1}), 0);
    void'(exp_q.pop_back());
    last_h = 0;
    last_t = 0;
    last_o = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    check("abort_no_done", done_count - saved, 0);
    convert(250, 1'b0);
    idle(2);

    // Exhaustive sweep with random idle gaps.
    saved = done_count;
    for (int v = 0; v < 256; v++) begin
      convert(v, 1'b0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);
    check("sweep_done_count", done_count - saved, 256);

    // Random operands, some back-to-back.
    for (int i = 0; i < 30; i++) begin
      convert(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
